// File: rtl/uart_apb_regif.sv
// APB3 slave register block for the UART: CTRL/BAUD/INTR registers, TX push with backpressure,
// RX pop, programmable wait states and error responses.
module uart_apb_regif #(
    parameter int ADDR_W        = 12,
    parameter int BAUD_W        = 16,
    parameter int NUM_INTR      = 8,
    parameter int WAIT_STATES   = 0,
    parameter int STALL_ON_FULL = 1
) (
    input  logic                pclk_i,
    input  logic                prst_ni,
    input  logic [ADDR_W-1:0]   paddr_i,
    input  logic                psel_i,
    input  logic                penable_i,
    input  logic                pwrite_i,
    input  logic [31:0]         pwdata_i,
    output logic [31:0]         prdata_o,
    output logic                pready_o,
    output logic                pslverr_o,
    output logic [7:0]          tx_data_o,
    output logic                tx_valid_o,
    input  logic                tx_ready_i,
    input  logic [7:0]          rx_data_i,
    input  logic                rx_valid_i,
    output logic                rx_ready_o,
    output logic                tx_en_o,
    output logic                rx_en_o,
    output logic [BAUD_W-1:0]   baud_div_o,
    input  logic [NUM_INTR-1:0] evt_i,
    output logic [NUM_INTR-1:0] intr_o,
    output logic                irq_o
);

    // state  | meaning
    // IDLE   | waiting for an APB setup phase
    // ACCESS | counting wait states, or holding a TXDATA write until the byte is accepted
    // RESP   | pready_o high for one cycle with prdata_o/pslverr_o
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;

    localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    logic [1:0]          state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                tx_phase_q, tx_phase_d;
    logic                pushed_q, pushed_d;
    logic                commit_q, commit_d;
    logic [31:0]         prdata_q, prdata_d;
    logic                pslverr_q, pslverr_d;
    logic                rx_ready_q, rx_ready_d;
    logic                tx_valid_q, tx_valid_d;
    logic [7:0]          tx_data_q, tx_data_d;
    logic [1:0]          ctrl_q, ctrl_d;
    logic [BAUD_W-1:0]   baud_q, baud_d;
    logic [NUM_INTR-1:0] en_q, en_d;
    logic [NUM_INTR-1:0] istate_q, istate_d;
    logic [NUM_INTR-1:0] intr_q;

    logic [2:0]          idx;
    logic                addr_ok;
    logic                acc_err;
    logic                is_tx_wr;
    logic                setup;
    logic                finish;
    logic                can_load;
    logic                load;
    logic [31:0]         rd_val;
    logic [NUM_INTR-1:0] w1c;
    logic [NUM_INTR-1:0] tset;
    logic                unused_bits;

    assign idx      = paddr_i[4:2];
    assign addr_ok  = (paddr_i[1:0] == 2'b00) && (paddr_i[ADDR_W-1:5] == '0);
    assign setup    = psel_i && !penable_i;
    assign can_load = !tx_valid_q || tx_ready_i;
    assign is_tx_wr = pwrite_i && (idx == 3'd2) && !acc_err;

    always_comb begin
        acc_err = !addr_ok;
        if (pwrite_i && (idx == 3'd3 || idx == 3'd4)) acc_err = 1'b1;
        if (!pwrite_i && (idx == 3'd2 || idx == 3'd7)) acc_err = 1'b1;
    end

    always_comb begin
        rd_val = '0;
        case (idx)
            3'd0:    rd_val[1:0]          = ctrl_q;
            3'd1:    rd_val[BAUD_W-1:0]   = baud_q;
            3'd3:    rd_val[7:0]          = rx_data_i;
            3'd4:    rd_val[1:0]          = {rx_valid_i, tx_ready_i};
            3'd5:    rd_val[NUM_INTR-1:0] = en_q;
            3'd6:    rd_val[NUM_INTR-1:0] = istate_q;
            default: rd_val = '0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        tx_phase_d = tx_phase_q;
        pushed_d   = pushed_q;
        commit_d   = 1'b0;
        prdata_d   = '0;
        pslverr_d  = 1'b0;
        rx_ready_d = 1'b0;
        load       = 1'b0;
        finish     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (setup) begin
                    cnt_d      = WAIT_LOAD;
                    tx_phase_d = 1'b0;
                    pushed_d   = 1'b0;
                    if (WAIT_STATES == 0) finish = 1'b1;
                    else                  state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (!psel_i) begin
                    state_d    = S_IDLE;
                    tx_phase_d = 1'b0;
                    pushed_d   = 1'b0;
                end else if (tx_phase_q) begin
                    // an older byte may still be pending; load ours once the slot frees up
                    if (!pushed_q && can_load) begin
                        load     = 1'b1;
                        pushed_d = 1'b1;
                    end else if (pushed_q && tx_valid_q && tx_ready_i) begin
                        state_d    = S_RESP;
                        tx_phase_d = 1'b0;
                        pushed_d   = 1'b0;
                    end
                end else if (cnt_q == 4'd0) begin
                    finish = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (finish) begin
            if (is_tx_wr && (STALL_ON_FULL != 0)) begin
                state_d    = S_ACCESS;
                tx_phase_d = 1'b1;
                load       = can_load;
                pushed_d   = can_load;
            end else begin
                state_d = S_RESP;
                if (acc_err) begin
                    pslverr_d = 1'b1;
                end else if (is_tx_wr) begin
                    if (tx_ready_i) load = 1'b1;
                    else            pslverr_d = 1'b1;
                end else if (pwrite_i) begin
                    commit_d = 1'b1;
                end else if (idx == 3'd3 && !rx_valid_i) begin
                    pslverr_d = 1'b1;
                end else begin
                    prdata_d   = rd_val;
                    rx_ready_d = (idx == 3'd3);
                end
            end
        end
    end

    always_comb begin
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        if (load) begin
            tx_valid_d = 1'b1;
            tx_data_d  = pwdata_i[7:0];
        end else if (tx_valid_q && tx_ready_i) begin
            tx_valid_d = 1'b0;
        end
    end

    // register writes land on the edge that closes the response cycle
    always_comb begin
        ctrl_d = ctrl_q;
        baud_d = baud_q;
        en_d   = en_q;
        w1c    = '0;
        tset   = '0;
        if (state_q == S_RESP && commit_q) begin
            case (idx)
                3'd0:    ctrl_d = pwdata_i[1:0];
                3'd1:    baud_d = pwdata_i[BAUD_W-1:0];
                3'd5:    en_d   = pwdata_i[NUM_INTR-1:0];
                3'd6:    w1c    = pwdata_i[NUM_INTR-1:0];
                3'd7:    tset   = pwdata_i[NUM_INTR-1:0];
                default: ;
            endcase
        end
        istate_d = (istate_q & ~w1c) | evt_i | tset;
    end

    always_ff @(posedge pclk_i or negedge prst_ni) begin
        if (!prst_ni) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            tx_phase_q <= 1'b0;
            pushed_q   <= 1'b0;
            commit_q   <= 1'b0;
            prdata_q   <= '0;
            pslverr_q  <= 1'b0;
            rx_ready_q <= 1'b0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
            ctrl_q     <= '0;
            baud_q     <= '0;
            en_q       <= '0;
            istate_q   <= '0;
            intr_q     <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            tx_phase_q <= tx_phase_d;
            pushed_q   <= pushed_d;
            commit_q   <= commit_d;
            prdata_q   <= prdata_d;
            pslverr_q  <= pslverr_d;
            rx_ready_q <= rx_ready_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
            ctrl_q     <= ctrl_d;
            baud_q     <= baud_d;
            en_q       <= en_d;
            istate_q   <= istate_d;
            intr_q     <= istate_d & en_d;
        end
    end

    assign prdata_o    = prdata_q;
    assign pready_o    = (state_q == S_RESP);
    assign pslverr_o   = pslverr_q;
    assign rx_ready_o  = rx_ready_q;
    assign tx_valid_o  = tx_valid_q;
    assign tx_data_o   = tx_data_q;
    assign tx_en_o     = ctrl_q[0];
    assign rx_en_o     = ctrl_q[1];
    assign baud_div_o  = baud_q;
    assign intr_o      = intr_q;
    assign irq_o       = |intr_q;
    assign unused_bits = ^pwdata_i;

endmodule

// File: tb/tb_uart_apb_regif.sv
// Directed bench for uart_apb_regif (WAIT_STATES=2, stalling TX) with a register-level model
// and a per-cycle compare of the sideband outputs.
module tb_uart_apb_regif;
    localparam int WS = 2;

    logic        pclk = 1'b0;
    logic        prst_n = 1'b0;
    logic [11:0] paddr = '0;
    logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [31:0] pwdata = '0;
    logic        tx_ready = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0;
    logic [7:0]  evt = '0;

    logic [31:0] prdata_o;
    logic        pready_o, pslverr_o, tx_valid_o, rx_ready_o, tx_en_o, rx_en_o, irq_o;
    logic [7:0]  tx_data_o, intr_o;
    logic [15:0] baud_div_o;

    logic [1:0]  m_ctrl = '0;
    logic [15:0] m_baud = '0;
    logic [7:0]  m_en = '0, m_intr = '0, m_txd = '0, push_d = '0;
    logic        m_pop = 1'b0, m_txv = 1'b0, push_pend = 1'b0, pw_valid = 1'b0, chk_en = 1'b0;
    int          pw_idx = 0;
    logic [31:0] pw_data = '0;
    int          nvec = 0, nerr = 0;
    logic [31:0] rd;
    logic        er;

    uart_apb_regif #(.WAIT_STATES(WS)) dut (
        .pclk_i(pclk), .prst_ni(prst_n), .paddr_i(paddr), .psel_i(psel), .penable_i(penable),
        .pwrite_i(pwrite), .pwdata_i(pwdata), .prdata_o(prdata_o), .pready_o(pready_o),
        .pslverr_o(pslverr_o), .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o),
        .tx_ready_i(tx_ready), .rx_data_i(rx_data), .rx_valid_i(rx_valid), .rx_ready_o(rx_ready_o),
        .tx_en_o(tx_en_o), .rx_en_o(rx_en_o), .baud_div_o(baud_div_o), .evt_i(evt),
        .intr_o(intr_o), .irq_o(irq_o)
    );

    always #5 pclk = ~pclk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    always begin
        @(posedge pclk);
        #2;
        if (chk_en) begin
            chk("tx_en", {31'd0, tx_en_o}, {31'd0, m_ctrl[0]});
            chk("rx_en", {31'd0, rx_en_o}, {31'd0, m_ctrl[1]});
            chk("baud", {16'd0, baud_div_o}, {16'd0, m_baud});
            chk("intr", {24'd0, intr_o}, {24'd0, m_intr & m_en});
            chk("irq", {31'd0, irq_o}, {31'd0, |(m_intr & m_en)});
            chk("rx_ready", {31'd0, rx_ready_o}, {31'd0, m_pop});
            chk("tx_valid", {31'd0, tx_valid_o}, {31'd0, m_txv});
            if (m_txv) chk("tx_data", {24'd0, tx_data_o}, {24'd0, m_txd});
        end
    end

    // advance one clock and move the model across the same edge
    task automatic tick();
        logic [7:0] e, clr, set;
        logic tr;
        e = evt;
        tr = tx_ready;
        @(posedge pclk);
        #1;
        clr = '0;
        set = '0;
        m_pop = 1'b0;
        if (pw_valid) begin
            case (pw_idx)
                0: m_ctrl = pw_data[1:0];
                1: m_baud = pw_data[15:0];
                5: m_en = pw_data[7:0];
                6: clr = pw_data[7:0];
                7: set = pw_data[7:0];
                default: ;
            endcase
            pw_valid = 1'b0;
        end
        m_intr = (m_intr & ~clr) | e | set;
        if (m_txv && tr) m_txv = 1'b0;
        if (push_pend) begin
            m_txv = 1'b1;
            m_txd = push_d;
            push_pend = 1'b0;
        end
    endtask

    task automatic apb(input logic [11:0] a, input logic w, input logic [31:0] wd,
                       input logic [7:0] evt_resp, input string nm,
                       output logic [31:0] rdo, output logic erro);
        logic bad, pop;
        logic [31:0] exp_rd;
        int idx, waits;
        idx = int'(a[4:2]);
        bad = (a[1:0] != 2'b00) || (a[11:5] != 7'd0);
        if (w && (idx == 3 || idx == 4)) bad = 1'b1;
        if (!w && (idx == 2 || idx == 7)) bad = 1'b1;
        exp_rd = '0;
        pop = 1'b0;
        if (!bad && !w) begin
            case (idx)
                0: exp_rd = {30'd0, m_ctrl};
                1: exp_rd = {16'd0, m_baud};
                3: if (rx_valid) begin exp_rd = {24'd0, rx_data}; pop = 1'b1; end
                   else bad = 1'b1;
                4: exp_rd = {30'd0, rx_valid, tx_ready};
                5: exp_rd = {24'd0, m_en};
                6: exp_rd = {24'd0, m_intr};
                default: ;
            endcase
        end
        paddr = a; pwrite = w; pwdata = wd; psel = 1'b1; penable = 1'b0;
        tick();
        penable = 1'b1;
        waits = 0;
        while (pready_o !== 1'b1 && waits < 40) begin
            tick();
            waits++;
        end
        chk({nm, "_waits"}, waits, WS);
        rdo = prdata_o;
        erro = pslverr_o;
        if (pready_o === 1'b1) begin
            chk({nm, "_rdata"}, prdata_o, exp_rd);
            chk({nm, "_err"}, {31'd0, pslverr_o}, {31'd0, bad});
            m_pop = pop;
            if (w && !bad) begin pw_valid = 1'b1; pw_idx = idx; pw_data = wd; end
            evt = evt_resp;
        end
        tick();
        evt = '0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    // TXDATA write; tx_ready_i stays low for 'hold' cycles after the byte is presented
    task automatic tx_write(input logic [7:0] d, input int hold, input string nm);
        int c;
        logic seen;
        paddr = 12'h008; pwrite = 1'b1; pwdata = {24'd0, d}; psel = 1'b1; penable = 1'b0;
        tx_ready = 1'b0;
        tick();
        penable = 1'b1;
        c = 0;
        seen = 1'b0;
        while (!seen && c < 40) begin
            if (c == WS - 1) begin push_pend = 1'b1; push_d = d; end
            tx_ready = (c == WS + hold) ? 1'b1 : 1'b0;
            chk($sformatf("%s_pready_c%0d", nm, c), {31'd0, pready_o},
                (c == WS + hold + 1) ? 32'd1 : 32'd0);
            if (pready_o === 1'b1) begin
                seen = 1'b1;
                chk({nm, "_err"}, {31'd0, pslverr_o}, 32'd0);
            end else begin
                tick();
                c++;
            end
        end
        if (!seen) chk({nm, "_timeout"}, 32'd0, 32'd1);
        tx_ready = 1'b0;
        tick();
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        #12;
        chk("rst_prdata", prdata_o, 32'd0);
        chk("rst_pready", {31'd0, pready_o}, 32'd0);
        chk("rst_pslverr", {31'd0, pslverr_o}, 32'd0);
        chk("rst_txv", {31'd0, tx_valid_o}, 32'd0);
        chk("rst_txd", {24'd0, tx_data_o}, 32'd0);
        chk("rst_rx_ready", {31'd0, rx_ready_o}, 32'd0);
        chk("rst_ctrl", {30'd0, rx_en_o, tx_en_o}, 32'd0);
        chk("rst_baud", {16'd0, baud_div_o}, 32'd0);
        chk("rst_intr", {23'd0, irq_o, intr_o}, 32'd0);
        @(negedge pclk);
        prst_n = 1'b1;
        tick();
        chk_en = 1'b1;

        // CTRL write/readback with wait states
        apb(12'h000, 1'b1, 32'h3, 8'h0, "ctrl_wr", rd, er);
        apb(12'h000, 1'b0, 32'h0, 8'h0, "ctrl_rd", rd, er);
        chk("ctrl_lit", rd, 32'h3);
        chk("ctrl_en_lit", {30'd0, rx_en_o, tx_en_o}, 32'h3);

        // BAUD truncation
        apb(12'h004, 1'b1, 32'hABCD1234, 8'h0, "baud_wr", rd, er);
        chk("baud_lit", {16'd0, baud_div_o}, 32'h1234);
        apb(12'h004, 1'b0, 32'h0, 8'h0, "baud_rd", rd, er);

        // TX with backpressure and without
        tx_write(8'h5A, 5, "tx5a");
        chk("tx5a_data_lit", {24'd0, tx_data_o}, 32'h5A);
        tx_write(8'hC3, 0, "txc3");

        // RX pop and empty read
        rx_valid = 1'b1; rx_data = 8'hA5;
        apb(12'h00C, 1'b0, 32'h0, 8'h0, "rx_full", rd, er);
        chk("rx_full_lit", rd, 32'hA5);
        rx_valid = 1'b0;
        apb(12'h00C, 1'b0, 32'h0, 8'h0, "rx_empty", rd, er);
        chk("rx_empty_lit", {rd[30:0], er}, 32'h1);

        // STATUS
        rx_valid = 1'b1;
        apb(12'h010, 1'b0, 32'h0, 8'h0, "status_a", rd, er);
        chk("status_lit", rd, 32'h2);
        rx_valid = 1'b0; tx_ready = 1'b1;
        apb(12'h010, 1'b0, 32'h0, 8'h0, "status_b", rd, er);
        tx_ready = 1'b0;

        // error responses leave all registers alone
        apb(12'h020, 1'b1, 32'hFF, 8'h0, "err_0x20", rd, er);
        chk("err_0x20_lit", {31'd0, er}, 32'h1);
        apb(12'h002, 1'b0, 32'h0, 8'h0, "err_0x02", rd, er);
        apb(12'h002, 1'b1, 32'h0, 8'h0, "err_0x02w", rd, er);
        apb(12'h010, 1'b1, 32'h3, 8'h0, "err_ro", rd, er);
        apb(12'h01C, 1'b0, 32'h0, 8'h0, "err_wo_test", rd, er);
        apb(12'h008, 1'b0, 32'h0, 8'h0, "err_wo_tx", rd, er);
        apb(12'h404, 1'b1, 32'h0, 8'h0, "err_upper", rd, er);

        // interrupts
        apb(12'h014, 1'b1, 32'h01, 8'h0, "inten_wr", rd, er);
        evt = 8'h01;
        tick();
        evt = 8'h00;
        chk("irq_lit", {31'd0, irq_o}, 32'h1);
        apb(12'h018, 1'b1, 32'h01, 8'h01, "w1c_vs_evt", rd, er);
        apb(12'h018, 1'b0, 32'h0, 8'h0, "istate_rd1", rd, er);
        chk("set_wins_lit", rd, 32'h1);
        apb(12'h018, 1'b1, 32'h01, 8'h0, "w1c", rd, er);
        chk("irq_clr_lit", {31'd0, irq_o}, 32'h0);
        apb(12'h01C, 1'b1, 32'h82, 8'h0, "intr_test", rd, er);
        apb(12'h014, 1'b1, 32'hFF, 8'h0, "inten_all", rd, er);
        chk("intr_test_lit", {24'd0, intr_o}, 32'h82);
        apb(12'h018, 1'b0, 32'h0, 8'h0, "istate_rd2", rd, er);

        // abort in ACCESS: no write, no pop
        paddr = 12'h000; pwrite = 1'b1; pwdata = 32'h0; psel = 1'b1; penable = 1'b0;
        tick(); penable = 1'b1;
        tick();
        chk("abort_wr_pready", {31'd0, pready_o}, 32'd0);
        psel = 1'b0; penable = 1'b0;
        tick();
        chk("abort_wr_pready2", {31'd0, pready_o}, 32'd0);
        tick();
        rx_valid = 1'b1; rx_data = 8'h3C;
        paddr = 12'h00C; pwrite = 1'b0; psel = 1'b1; penable = 1'b0;
        tick(); penable = 1'b1;
        tick();
        psel = 1'b0; penable = 1'b0;
        tick(); tick();
        rx_valid = 1'b0;
        apb(12'h000, 1'b0, 32'h0, 8'h0, "post_abort_ctrl", rd, er);
        chk("post_abort_lit", rd, 32'h3);

        // async reset in the middle of a TX stall
        paddr = 12'h008; pwrite = 1'b1; pwdata = 32'h77; psel = 1'b1; penable = 1'b0;
        tx_ready = 1'b0;
        tick(); penable = 1'b1;
        for (int c = 0; c < WS + 3; c++) begin
            if (c == WS - 1) begin push_pend = 1'b1; push_d = 8'h77; end
            tick();
        end
        chk("pre_rst_txv_lit", {31'd0, tx_valid_o}, 32'h1);
        #2;
        prst_n = 1'b0;
        chk_en = 1'b0;
        #1;
        chk("arst_txv", {31'd0, tx_valid_o}, 32'd0);
        chk("arst_pready", {31'd0, pready_o}, 32'd0);
        chk("arst_ctrl", {30'd0, rx_en_o, tx_en_o}, 32'd0);
        chk("arst_baud", {16'd0, baud_div_o}, 32'd0);
        chk("arst_intr", {23'd0, irq_o, intr_o}, 32'd0);
        m_ctrl = '0; m_baud = '0; m_en = '0; m_intr = '0; m_txv = 1'b0; m_pop = 1'b0;
        push_pend = 1'b0; pw_valid = 1'b0;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        @(negedge pclk);
        @(negedge pclk);
        prst_n = 1'b1;
        tick();
        chk_en = 1'b1;
        apb(12'h004, 1'b0, 32'h0, 8'h0, "post_rst_baud", rd, er);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
